// File: rtl/adc_fir_feeder.sv
`default_nettype none
// ============================================================================
// Module   : adc_fir_feeder
// Purpose  : Clocks one 16-bit sample out of a 3-wire serial ADC, hands it to
//            the 4-tap FIR filter as a parallel word with a one-cycle enable,
//            waits for the filter's done flag and captures the 18-bit result
//            into a valid/ready output register with sticky overrun.
// Revision : 1.0 - initial release
// ============================================================================
module adc_fir_feeder #(
  parameter int SCLK_DIV = 2,  // clk cycles per sclk half-period (>=1)
  parameter int CONV_GAP = 2   // cs_n-high cycles between conversions (>=1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_sdo,
  output logic [15:0] fir_data,
  output logic        fir_enable,
  input  logic        fir_done,
  input  logic [17:0] fir_result,
  output logic [17:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        overrun,
  output logic        busy
);

  // Counter widths; a one-wide counter still works when the terminal count is 0.
  localparam int c_DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int c_GAP_W = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST    = c_DIV_W'(SCLK_DIV - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST    = c_GAP_W'(CONV_GAP - 1);
  // 16 full sclk periods are 32 toggles; the last one is a falling edge.
  localparam logic [4:0]         c_LAST_TOGGLE = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [4:0]         r_tog_cnt;
  logic               r_sclk;
  logic [15:0]        r_shift;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [15:0]        r_fir_data;
  logic               r_fir_enable;
  logic [17:0]        r_res_data;
  logic               r_res_valid;
  logic               r_overrun;

  logic w_sclk_toggle;
  logic w_sclk_rise;
  logic w_conv_done;
  logic w_gap_done;
  logic w_result_in;
  logic w_capture;
  logic w_drop;
  logic w_cs_n;
  logic w_busy;

  // Event decode shared by the FSM and the datapath registers.
  always_comb begin
    w_sclk_toggle = (r_state == S_CONV) && (r_div_cnt == c_DIV_LAST);
    w_sclk_rise   = w_sclk_toggle && !r_sclk;
    w_conv_done   = w_sclk_toggle && (r_tog_cnt == c_LAST_TOGGLE);
    w_gap_done    = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);
    // A done flag outside WAIT belongs to nothing we launched, so it is ignored.
    w_result_in   = (r_state == S_WAIT) && fir_done;
    w_capture     = w_result_in && (!r_res_valid || res_ready);
    w_drop        = w_result_in && r_res_valid && !res_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    w_cs_n       = 1'b1;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_next_state = S_CONV;
        end
      end
      S_CONV: begin
        w_cs_n = 1'b0;
        if (w_conv_done) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (fir_done) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        // Start is only re-examined here, so dropping it never aborts a sample.
        if (w_gap_done) begin
          w_next_state = start ? S_CONV : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Serial clock generator: half-period divider and toggle counter, parked low outside CONV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tog_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (r_state == S_CONV) begin
      if (w_sclk_toggle) begin
        r_div_cnt <= '0;
        r_tog_cnt <= r_tog_cnt + 5'd1;
        r_sclk    <= ~r_sclk;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end
    end else begin
      r_div_cnt <= '0;
      r_tog_cnt <= '0;
      r_sclk    <= 1'b0;
    end
  end

  // Sample shift register: ADC data enters the LSB on every sclk rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_sclk_rise) begin
      r_shift <= {r_shift[14:0], adc_sdo};
    end
  end

  // Inter-conversion gap counter, restarted on every GAP entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Filter handoff: word loaded in LOAD, enable pulses in the cycle after LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fir_data   <= '0;
      r_fir_enable <= 1'b0;
    end else begin
      r_fir_enable <= (r_state == S_LOAD);
      if (r_state == S_LOAD) begin
        r_fir_data <= r_shift;
      end
    end
  end

  // Result register: capture beats consumption; a result arriving on a full, stalled register is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_res_data  <= fir_result;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign adc_cs_n   = w_cs_n;
  assign adc_sclk   = r_sclk;
  assign fir_data   = r_fir_data;
  assign fir_enable = r_fir_enable;
  assign res_data   = r_res_data;
  assign res_valid  = r_res_valid;
  assign overrun    = r_overrun;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_fir_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_fir_feeder
// Purpose  : Self-checking bench for adc_fir_feeder with a serial ADC model,
//            a latency-4 filter model and a result-register reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_fir_feeder;

  localparam int SCLK_DIV    = 2;
  localparam int CONV_GAP    = 2;
  localparam int CONV_CYCLES = 32 * SCLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        adc_sdo = 1'b0;
  logic        fir_done = 1'b0;
  logic [17:0] fir_result = '0;
  logic        res_ready = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [15:0] fir_data;
  logic        fir_enable;
  logic [17:0] res_data;
  logic        res_valid;
  logic        overrun;
  logic        busy;

  adc_fir_feeder #(.SCLK_DIV(SCLK_DIV), .CONV_GAP(CONV_GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_sdo    (adc_sdo),
    .fir_data   (fir_data),
    .fir_enable (fir_enable),
    .fir_done   (fir_done),
    .fir_result (fir_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC model and serial-link checks ----------------
  logic [15:0] adc_word = 16'hA5C3;
  int          rises = 0;
  int          win_len = 0;
  bit          win_aborted = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_en = 1'b0;
  logic [15:0] exp_word = '0;
  bit          word_pending = 0;
  int          since_close = 100;
  int          enable_cnt = 0;
  logic [15:0] m_fir = '0;

  always @(negedge clk) begin
    since_close++;
    if (adc_cs_n === 1'b0) begin
      win_len++;
      if (adc_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
    end else begin
      if (prev_cs === 1'b0 && !win_aborted) begin
        check("sclk_rises_in_window", rises, 16);
        check("cs_low_window_len", win_len, CONV_CYCLES);
        exp_word     = adc_word;
        word_pending = 1;
        since_close  = 0;
      end
      if (adc_cs_n === 1'b1) check("sclk_idle_low", adc_sclk, 1'b0);
      rises       = 0;
      win_len     = 0;
      win_aborted = 0;
    end
    if (fir_enable === 1'b1) begin
      enable_cnt++;
      check("fir_enable_not_back_to_back", prev_en, 1'b0);
      check("fir_enable_has_sample", word_pending, 1'b1);
      check("fir_enable_latency", since_close, 1);
      m_fir        = exp_word;
      word_pending = 0;
    end
    if (rst_n === 1'b1) check("fir_data", fir_data, m_fir);
    adc_sdo   = (rises < 16) ? adc_word[15 - rises] : 1'b0;
    prev_sclk = adc_sclk;
    prev_cs   = adc_cs_n;
    prev_en   = fir_enable;
  end

  // ---------------- Filter model: done 4 cycles after enable ----------------
  logic [3:0]  pipe = '0;
  logic [17:0] results[$];
  int          ready_mode = 1;  // 0: never ready, 1: always ready, 2: ready only with done
  int          done_cnt = 0;

  always @(negedge clk) begin
    fir_done = pipe[3];
    if (pipe[3]) begin
      done_cnt++;
      fir_result = (results.size() > 0) ? results.pop_front() : 18'h0;
    end
    pipe = {pipe[2:0], (fir_enable === 1'b1)};
    case (ready_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = fir_done;
    endcase
  end

  // ---------------- Result register reference model ----------------
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;
  logic [17:0] m_data = '0;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_data  = '0;
      m_fir   = '0;
    end else if (fir_done) begin
      if (!m_valid || res_ready) begin
        m_data  = fir_result;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
  end

  // Cycle-by-cycle comparison of the result channel against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("res_valid", res_valid, m_valid);
      check("res_data", res_data, m_data);
      check("overrun", overrun, m_ovr);
    end
  end

  // ---------------- Helpers ----------------
  int wait_target = 0;

  function automatic logic cond(input int sel);
    case (sel)
      0:       return adc_cs_n === 1'b0;
      1:       return res_valid === 1'b1;
      2:       return busy === 1'b0;
      3:       return done_cnt >= wait_target;
      4:       return overrun === 1'b1;
      default: return rises >= wait_target;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name);
    int n = 0;
    while (!cond(sel) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cond(sel)) begin
      errors++;
      $display("FAIL timeout_%s: condition not met, required within %0d cycles", name, limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, adc_cs_n, 1'b1);
    check({tag, "_sclk"}, adc_sclk, 1'b0);
    check({tag, "_fir_data"}, fir_data, 16'h0);
    check({tag, "_fir_enable"}, fir_enable, 1'b0);
    check({tag, "_res_data"}, res_data, 18'h0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Global guard in case a wait slips through unbounded.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed stimulus ----------------
  initial begin
    int cs_low_cnt;
    int valid_cnt;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Sample 0xA5C3, result 0x2ABCD, downstream always ready, single sample.
    adc_word   = 16'hA5C3;
    ready_mode = 1;
    results.push_back(18'h2ABCD);
    start = 1'b1;
    @(negedge clk);
    check("t1_cs_low_next_edge", adc_cs_n, 1'b0);
    start = 1'b0;
    wait_for(1, 200, "t1_valid");
    check("t1_res_data", res_data, 18'h2ABCD);
    check("t1_model_data", m_data, 18'h2ABCD);
    check("t1_fir_data", fir_data, 16'hA5C3);
    valid_cnt = 0;
    repeat (4) begin
      if (res_valid === 1'b1) valid_cnt++;
      @(negedge clk);
    end
    check("t1_valid_cycles", valid_cnt, 1);
    wait_for(2, 50, "t1_idle");
    check("t1_enable_pulses", enable_cnt, 1);

    // Downstream stalled over two back-to-back samples: second result dropped.
    ready_mode = 0;
    adc_word   = 16'h0F0F;
    results.push_back(18'h12345);
    results.push_back(18'h3FFFF);
    start = 1'b1;
    wait_for(1, 200, "t2_first_valid");
    check("t2_first_res", res_data, 18'h12345);
    check("t2_no_overrun_yet", overrun, 1'b0);
    adc_word = 16'hF00D;
    wait_for(4, 200, "t2_overrun");
    start = 1'b0;
    check("t2_res_kept", res_data, 18'h12345);
    check("t2_valid_kept", res_valid, 1'b1);
    check("t2_overrun_set", overrun, 1'b1);
    check("t2_fir_data_second", fir_data, 16'hF00D);
    wait_for(2, 50, "t2_idle");
    ready_mode = 1;
    repeat (3) @(negedge clk);
    check("t2_valid_drained", res_valid, 1'b0);
    check("t2_overrun_sticky", overrun, 1'b1);

    // Ready coincides with the second done: new result loads, no overrun.
    pulse_reset();
    check("t3_overrun_cleared", overrun, 1'b0);
    ready_mode  = 2;
    adc_word    = 16'h8000;
    results.push_back(18'h00001);
    results.push_back(18'h20000);
    wait_target = done_cnt + 2;
    start = 1'b1;
    wait_for(1, 200, "t3_first_valid");
    check("t3_first_res", res_data, 18'h00001);
    wait_for(3, 200, "t3_second_done");
    start = 1'b0;
    @(negedge clk);
    check("t3_new_res", res_data, 18'h20000);
    check("t3_valid_stays", res_valid, 1'b1);
    check("t3_no_overrun", overrun, 1'b0);
    wait_for(2, 50, "t3_idle");
    ready_mode = 1;
    repeat (3) @(negedge clk);

    // Start dropped halfway through CONV: sample completes, then IDLE.
    pulse_reset();
    adc_word = 16'h3C5A;
    results.push_back(18'h15555);
    start = 1'b1;
    @(negedge clk);
    repeat (CONV_CYCLES / 2) @(negedge clk);
    check("t4_still_converting", adc_cs_n, 1'b0);
    start = 1'b0;
    wait_for(1, 200, "t4_valid");
    check("t4_res_data", res_data, 18'h15555);
    check("t4_fir_data", fir_data, 16'h3C5A);
    wait_for(2, 50, "t4_idle");
    cs_low_cnt = 0;
    repeat (100) begin
      if (adc_cs_n !== 1'b1) cs_low_cnt++;
      @(negedge clk);
    end
    check("t4_no_new_conversion", cs_low_cnt, 0);
    check("t4_busy_low", busy, 1'b0);

    // One-cycle reset during CONV at bit 7, then a clean fresh conversion.
    adc_word = 16'h1234;
    results.push_back(18'h0BEEF);
    start = 1'b1;
    wait_target = 7;
    wait_for(5, 200, "t5_bit7");
    rst_n       = 1'b0;
    win_aborted = 1;
    @(negedge clk);
    check_reset_outputs("t5_midreset");
    rst_n    = 1'b1;
    adc_word = 16'h8001;
    wait_for(1, 200, "t5_valid");
    start = 1'b0;
    check("t5_res_data", res_data, 18'h0BEEF);
    check("t5_fir_data", fir_data, 16'h8001);
    wait_for(2, 100, "t5_idle");
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
